// File: rtl/alu_issue_queue.sv
// ALU reservation station: DEPTH entries, NUM_CDB-port operand capture with dispatch bypass, one issue per cycle.
// Build option RS_AGE_ORDER_EN: oldest-ready-first select via an age matrix; otherwise lowest-index ready wins.
module alu_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int CTL_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [CTL_W-1:0]           disp_ctl,
    input  logic [TAG_W-1:0]           disp_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [DATA_W-1:0]          disp_src1_data,
    input  logic [DATA_W-1:0]          disp_src2_data,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [CTL_W-1:0]           iss_ctl,
    output logic [TAG_W-1:0]           iss_tag,
    output logic [DATA_W-1:0]          iss_op1,
    output logic [DATA_W-1:0]          iss_op2,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [TAG_W-1:0]  tag;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_data;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_data;
    } entry_t;

    logic [DEPTH-1:0]  valid_q, valid_d;
    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  sel_oh;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              disp_fire;
    logic              iss_fire;
    logic [DATA_W:0]   wake1 [DEPTH];
    logic [DATA_W:0]   wake2 [DEPTH];
    logic [DATA_W:0]   byp1, byp2;
    entry_t            new_ent;

    // {hit, data}; ports scanned high to low so the lowest matching port is the one kept
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        for (int p = NUM_CDB-1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == t))
                r = {1'b1, cdb_data[p*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
            wake1[i] = cdb_lookup(ent_q[i].s1_tag);
            wake2[i] = cdb_lookup(ent_q[i].s2_tag);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!valid_q[i]) free_idx = IDX_W'(i);
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[i][j] = 1: entry j was dispatched before entry i and is still live
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ready[i] && ((ready & older_q[i]) == '0)) sel_oh[i] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
        if (iss_fire) begin
            older_d[sel_idx] = '0;
            for (int i = 0; i < DEPTH; i++) older_d[i][sel_idx] = 1'b0;
        end
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
            older_d[free_idx] = valid_q & ~(iss_fire ? sel_oh : '0);
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) older_q[i] <= '0;
            else        older_q[i] <= older_d[i];
        end
    end
`else
    always_comb begin
        sel_oh = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sel_oh[i]) sel_idx = sel_idx | IDX_W'(i);
    end

    assign iss_valid  = |ready;
    assign iss_fire   = iss_valid && iss_ready;
    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign count      = count_q;

    assign iss_ctl = iss_valid ? ent_q[sel_idx].ctl     : '0;
    assign iss_tag = iss_valid ? ent_q[sel_idx].tag     : '0;
    assign iss_op1 = iss_valid ? ent_q[sel_idx].s1_data : '0;
    assign iss_op2 = iss_valid ? ent_q[sel_idx].s2_data : '0;

    always_comb begin
        byp1             = cdb_lookup(disp_src1_tag);
        byp2             = cdb_lookup(disp_src2_tag);
        new_ent.ctl      = disp_ctl;
        new_ent.tag      = disp_tag;
        new_ent.s1_rdy   = disp_src1_rdy | byp1[DATA_W];
        new_ent.s1_tag   = disp_src1_tag;
        new_ent.s1_data  = disp_src1_rdy ? disp_src1_data : byp1[DATA_W-1:0];
        new_ent.s2_rdy   = disp_src2_rdy | byp2[DATA_W];
        new_ent.s2_tag   = disp_src2_tag;
        new_ent.s2_data  = disp_src2_rdy ? disp_src2_data : byp2[DATA_W-1:0];
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (valid_q[i] && !ent_q[i].s1_rdy && wake1[i][DATA_W]) begin
                ent_d[i].s1_rdy  = 1'b1;
                ent_d[i].s1_data = wake1[i][DATA_W-1:0];
            end
            if (valid_q[i] && !ent_q[i].s2_rdy && wake2[i][DATA_W]) begin
                ent_d[i].s2_rdy  = 1'b1;
                ent_d[i].s2_data = wake2[i][DATA_W-1:0];
            end
        end
        if (iss_fire) valid_d[sel_idx] = 1'b0;
        // free_idx comes from pre-issue occupancy, so an issuing slot is never reused in the same cycle
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            ent_d[free_idx]   = new_ent;
        end
        if (disp_fire && !iss_fire)      count_d = count_q + 1'b1;
        else if (!disp_fire && iss_fire) count_d = count_q - 1'b1;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Parametrised ALU reservation station, the successor to the single-CDB ALU station. Sits between rename/dispatch and the ALU execute stage. Holds up to DEPTH renamed ALU operations and captures operands from NUM_CDB common-data-bus broadcast ports, including a same-cycle bypass at dispatch. Issues one ready operation per cycle through a valid/ready handshake, oldest first by dispatch order.

## Interface
Parameters:
- DEPTH, 8: entry count, ≥2.
- NUM_CDB, 2: number of CDB broadcast ports, ≥1.
- TAG_W, 6: ROB/physical tag width.
- DATA_W, 32: operand width.
- CTL_W, 5: ALU control width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- flush  in  1  branch-mispredict flush. Kills all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_ctl  in  CTL_W  ALU control.
- disp_tag  in  TAG_W  destination ROB tag.
- disp_src1_rdy, disp_src2_rdy  in  1 each  operand value present. An immediate arrives as src2 with rdy=1.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  producer tag when not ready.
- disp_src1_data, disp_src2_data  in  DATA_W each  operand value when ready.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed tags. Port p occupies bits [p*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  packed results, same packing.
- iss_valid  out  1  a ready entry is selected.
- iss_ready  in  1  ALU accepts.
- iss_ctl, iss_tag, iss_op1, iss_op2  out  CTL_W/TAG_W/DATA_W/DATA_W  selected entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry fields: valid, ctl, tag, and per source {rdy, qtag, data}. An entry is ready when valid && src1.rdy && src2.rdy.
- Dispatch fires on disp_valid && disp_ready. It writes the lowest-index free entry.
- Dispatch bypass: for a source with rdy=0, if any cdb_valid[p] has cdb_tag[p] == src tag in the same cycle, the entry stores rdy=1 and data=cdb_data[p].
- Wakeup: each cycle, every valid stored entry compares each not-ready source against all CDB ports. On a match it sets rdy=1 and latches the data.
- If several ports match the same tag, the lowest port index wins.
- Select: among ready entries, iss_* presents the entry dispatched earliest. Age is tracked by an age matrix updated on dispatch and cleared on free.
- When iss_valid=0, iss_ctl/tag/op1/op2 are driven 0.
- Issue fires on iss_valid && iss_ready. The selected entry is freed at that edge.
- disp_ready = (count < DEPTH). A slot freed by issue in the same cycle cannot be reused that cycle.
- count: +1 on dispatch, −1 on issue, unchanged when both fire.
- flush: takes priority over everything. At the edge, all entries are invalidated and count=0. Dispatch, wakeup and issue in that cycle are discarded; iss_valid still reflects pre-flush state combinationally.

## Timing
- Reset (rst_n=0 at edge): all entries invalid, age state cleared, count=0. The outputs then read iss_valid=0, iss_* = 0 and disp_ready=1.
- Dispatch with both sources ready (or bypassed): iss_valid can assert the cycle after acceptance. Minimum dispatch→issue latency is 1 cycle.
- CDB broadcast at cycle t for a stored entry: the entry is ready at t+1 and can issue at t+1.
- iss_* are combinational from stored state. They hold stable while iss_valid && !iss_ready, unless an older entry becomes ready, in which case selection may change.
- Full (count=DEPTH): disp_ready=0. disp_valid is ignored and entry state is untouched.
- Empty: iss_valid=0. No entry is freed regardless of iss_ready.

## Configuration
- RS_AGE_ORDER_EN defined: select is oldest-ready-first via the age matrix, as described above.
- RS_AGE_ORDER_EN undefined: the age matrix is not built. Select is the lowest-index ready entry. All other behaviour is identical.

## Test plan
- Reset, then dispatch ctl=3 tag=5 src1=10 (rdy) src2=20 (rdy) with iss_ready=1 → next cycle iss_valid=1, tag=5, op1=10, op2=20. The cycle after that, count=0.
- Dispatch tag=7 with src1 waiting on qtag=12. Two cycles later, cdb_valid[1]=1 with tag=12, data=0xBEEF → iss_valid=1 the following cycle with op1=0xBEEF.
- Dispatch tag=8 with src2 qtag=4 while cdb port 0 broadcasts tag=4, data=99 in the same cycle → next cycle iss_valid=1, op2=99 (bypass).
- Fill DEPTH=8 entries, all waiting, with iss_ready=0 → disp_ready=0 and count=8. Extra disp_valid is ignored. flush → next cycle count=0, disp_ready=1, iss_valid=0.
- With RS_AGE_ORDER_EN: dispatch A (waiting) into entry 0, then B (ready) into entry 1, then wake A → A and B both ready, iss_tag=A. Without the macro, the same sequence also gives A, since A is the lower index. Repeat with A placed in entry 1 after a free: with the macro, A issues first; without it, the entry-0 instruction issues first.
- Dispatch and issue in the same cycle at count=3 → count stays 3. A tag matching two CDB ports in the same cycle → the data from port 0 is captured.
